// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline back end: datapath widths,
// syscall codes and the write-back syscall FSM state encoding.
package mips_pkg;

  localparam int MIPS_DATA_W = 32;
  localparam int MIPS_REG_AW = 5;
  localparam int MIPS_CON_W  = 8;

  localparam int SYS_PRINT_CHAR = 11;
  localparam int SYS_EXIT       = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EMIT   = 2'd1,
    HALTED = 2'd2
  } wb_state_e;

  // Saturating increment for wide event counters.
  function automatic logic [63:0] sat_inc64(input logic [63:0] v);
    logic [63:0] r;
    if (&v) begin
      r = v;
    end else begin
      r = v + 64'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register. Flush has priority over hold; a hold keeps
// every field, except that a syscall already taken by the FSM while the
// register is held is cleared so it cannot be executed twice.
module mem_wb_reg #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CON_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              hold,
  input  logic              consume,
  input  logic              reg_write_i,
  input  logic              mem_to_reg_i,
  input  logic              syscall_i,
  input  logic [DATA_W-1:0] read_data_i,
  input  logic [DATA_W-1:0] alu_out_i,
  input  logic [REG_AW-1:0] write_reg_i,
  input  logic [DATA_W-1:0] v0_i,
  input  logic [CON_W-1:0]  a0_i,
  output logic              reg_write_o,
  output logic              mem_to_reg_o,
  output logic              syscall_o,
  output logic              valid_o,
  output logic [DATA_W-1:0] read_data_o,
  output logic [DATA_W-1:0] alu_out_o,
  output logic [REG_AW-1:0] write_reg_o,
  output logic [DATA_W-1:0] v0_o,
  output logic [CON_W-1:0]  a0_o
);

  logic              reg_write_q, reg_write_d;
  logic              mem_to_reg_q, mem_to_reg_d;
  logic              syscall_q, syscall_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] read_data_q, read_data_d;
  logic [DATA_W-1:0] alu_out_q, alu_out_d;
  logic [REG_AW-1:0] write_reg_q, write_reg_d;
  logic [DATA_W-1:0] v0_q, v0_d;
  logic [CON_W-1:0]  a0_q, a0_d;

  // Next-state selection: flush > hold > capture.
  always_comb begin
    reg_write_d  = reg_write_q;
    mem_to_reg_d = mem_to_reg_q;
    syscall_d    = syscall_q;
    valid_d      = valid_q;
    read_data_d  = read_data_q;
    alu_out_d    = alu_out_q;
    write_reg_d  = write_reg_q;
    v0_d         = v0_q;
    a0_d         = a0_q;
    if (flush) begin
      reg_write_d = 1'b0;
      syscall_d   = 1'b0;
      valid_d     = 1'b0;
    end else if (hold) begin
      if (consume) begin
        syscall_d = 1'b0;
      end else begin
        syscall_d = syscall_q;
      end
    end else begin
      reg_write_d  = reg_write_i;
      mem_to_reg_d = mem_to_reg_i;
      syscall_d    = syscall_i;
      valid_d      = 1'b1;
      read_data_d  = read_data_i;
      alu_out_d    = alu_out_i;
      write_reg_d  = write_reg_i;
      v0_d         = v0_i;
      a0_d         = a0_i;
    end
  end

  // Register storage with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      syscall_q    <= 1'b0;
      valid_q      <= 1'b0;
      read_data_q  <= {DATA_W{1'b0}};
      alu_out_q    <= {DATA_W{1'b0}};
      write_reg_q  <= {REG_AW{1'b0}};
      v0_q         <= {DATA_W{1'b0}};
      a0_q         <= {CON_W{1'b0}};
    end else begin
      reg_write_q  <= reg_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      syscall_q    <= syscall_d;
      valid_q      <= valid_d;
      read_data_q  <= read_data_d;
      alu_out_q    <= alu_out_d;
      write_reg_q  <= write_reg_d;
      v0_q         <= v0_d;
      a0_q         <= a0_d;
    end
  end

  assign reg_write_o  = reg_write_q;
  assign mem_to_reg_o = mem_to_reg_q;
  assign syscall_o    = syscall_q;
  assign valid_o      = valid_q;
  assign read_data_o  = read_data_q;
  assign alu_out_o    = alu_out_q;
  assign write_reg_o  = write_reg_q;
  assign v0_o         = v0_q;
  assign a0_o         = a0_q;

endmodule

// File: rtl/writeback_stage.sv
// Write-back stage: MEM/WB register, result mux, register-file write port
// and retirement-time syscall FSM (print-char over a valid/ready console
// handshake, exit halts the core).
// Optional: define WB_INSTRET_COUNTER_EN to add a 64-bit saturating
// retired-instruction counter output (instret).
module writeback_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = MIPS_DATA_W,
  parameter int REG_AW = MIPS_REG_AW,
  parameter int CON_W  = MIPS_CON_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_w,
  input  logic              flush_w,
  input  logic              RegWriteM,
  input  logic              MemToRegM,
  input  logic              syscallM,
  input  logic [DATA_W-1:0] ReadDataM,
  input  logic [DATA_W-1:0] ALUOutM,
  input  logic [REG_AW-1:0] WriteRegM,
  input  logic [DATA_W-1:0] v0M,
  input  logic [DATA_W-1:0] a0M,
  output logic              RegWriteW,
  output logic [REG_AW-1:0] WriteRegW,
  output logic [DATA_W-1:0] ResultW,
  output logic              stall_req,
  output logic              con_valid,
  output logic [CON_W-1:0]  con_data,
  input  logic              con_ready,
`ifdef WB_INSTRET_COUNTER_EN
  output logic [63:0]       instret,
`endif
  output logic              halt
);

  logic              reg_write_s, mem_to_reg_s, syscall_s, valid_s;
  logic [DATA_W-1:0] read_data_s, alu_out_s, v0_s;
  logic [REG_AW-1:0] write_reg_s;
  logic [CON_W-1:0]  a0_s;
  logic              hold_s;
  logic              take_sys_s;
  logic              unused_a0_s;

  wb_state_e         state_q, state_d;
  logic [CON_W-1:0]  con_data_q, con_data_d;

  // Only the low character byte of $a0 is ever emitted.
  assign unused_a0_s = ^a0M[DATA_W-1:CON_W];

  // The register holds for an external stall or while the FSM is busy.
  assign hold_s     = stall_w | stall_req;
  assign take_sys_s = valid_s & syscall_s & (state_q == IDLE);

  mem_wb_reg #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW),
    .CON_W  (CON_W)
  ) u_mem_wb_reg (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush_w),
    .hold         (hold_s),
    .consume      (take_sys_s),
    .reg_write_i  (RegWriteM),
    .mem_to_reg_i (MemToRegM),
    .syscall_i    (syscallM),
    .read_data_i  (ReadDataM),
    .alu_out_i    (ALUOutM),
    .write_reg_i  (WriteRegM),
    .v0_i         (v0M),
    .a0_i         (a0M[CON_W-1:0]),
    .reg_write_o  (reg_write_s),
    .mem_to_reg_o (mem_to_reg_s),
    .syscall_o    (syscall_s),
    .valid_o      (valid_s),
    .read_data_o  (read_data_s),
    .alu_out_o    (alu_out_s),
    .write_reg_o  (write_reg_s),
    .v0_o         (v0_s),
    .a0_o         (a0_s)
  );

  // FSM state and latched console character.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      con_data_q <= {CON_W{1'b0}};
    end else begin
      state_q    <= state_d;
      con_data_q <= con_data_d;
    end
  end

  // Next state: decode a retiring syscall in IDLE, wait for the handshake in EMIT.
  always_comb begin
    state_d    = state_q;
    con_data_d = con_data_q;
    case (state_q)
      IDLE: begin
        if (take_sys_s) begin
          if (v0_s == DATA_W'(SYS_PRINT_CHAR)) begin
            state_d    = EMIT;
            con_data_d = a0_s;
          end else if (v0_s == DATA_W'(SYS_EXIT)) begin
            state_d = HALTED;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      EMIT: begin
        if (con_ready) begin
          state_d = IDLE;
        end else begin
          state_d = EMIT;
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decoded from registered state only (no path from con_ready).
  always_comb begin
    con_valid = (state_q == EMIT);
    stall_req = (state_q != IDLE);
    halt      = (state_q == HALTED);
    RegWriteW = reg_write_s & valid_s & (state_q == IDLE) & ~halt;
    WriteRegW = write_reg_s;
    con_data  = con_data_q;
    if (mem_to_reg_s) begin
      ResultW = read_data_s;
    end else begin
      ResultW = alu_out_s;
    end
  end

`ifdef WB_INSTRET_COUNTER_EN
  logic [63:0] instret_q, instret_d;

  // Count valid instructions leaving WB; IDLE excludes HALTED, so halt freezes it.
  always_comb begin
    if (valid_s && (state_q == IDLE) && !hold_s) begin
      instret_d = sat_inc64(instret_q);
    end else begin
      instret_d = instret_q;
    end
  end

  // Retired-instruction counter storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret_q <= 64'd0;
    end else begin
      instret_q <= instret_d;
    end
  end

  assign instret = instret_q;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Directed self-checking bench for writeback_stage: a vector table for
// single-cycle datapath behaviour plus hand-written syscall sequences.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_w, flush_w;
  logic        RegWriteM, MemToRegM, syscallM;
  logic [31:0] ReadDataM, ALUOutM, v0M, a0M;
  logic [4:0]  WriteRegM;
  logic        RegWriteW;
  logic [4:0]  WriteRegW;
  logic [31:0] ResultW;
  logic        stall_req, con_valid, con_ready, halt;
  logic [7:0]  con_data;
`ifdef WB_INSTRET_COUNTER_EN
  logic [63:0] instret;
`endif

  int total = 0;
  int bad   = 0;
  logic [7:0] hs_q[$];

  always #5 clk = ~clk;

  writeback_stage dut (
    .clk(clk), .rst_n(rst_n), .stall_w(stall_w), .flush_w(flush_w),
    .RegWriteM(RegWriteM), .MemToRegM(MemToRegM), .syscallM(syscallM),
    .ReadDataM(ReadDataM), .ALUOutM(ALUOutM), .WriteRegM(WriteRegM),
    .v0M(v0M), .a0M(a0M), .RegWriteW(RegWriteW), .WriteRegW(WriteRegW),
    .ResultW(ResultW), .stall_req(stall_req), .con_valid(con_valid),
    .con_data(con_data), .con_ready(con_ready),
`ifdef WB_INSTRET_COUNTER_EN
    .instret(instret),
`endif
    .halt(halt)
  );

  // Record every completed console handshake.
  always @(posedge clk) begin
    if (rst_n && con_valid && con_ready) hs_q.push_back(con_data);
  end

  typedef struct {
    logic        flush;
    logic        rw;
    logic        m2r;
    logic        sys;
    logic [31:0] rd;
    logic [31:0] alu;
    logic [4:0]  wr;
    logic [31:0] v0;
    logic        chk_data;
    logic        exp_rw;
    logic [4:0]  exp_wr;
    logic [31:0] exp_res;
    logic        exp_stall;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic fl, input logic rw, input logic m2r, input logic sys,
                       input logic [31:0] rd, input logic [31:0] alu, input logic [4:0] wr,
                       input logic [31:0] v0, input logic [31:0] a0);
    flush_w = fl; RegWriteM = rw; MemToRegM = m2r; syscallM = sys;
    ReadDataM = rd; ALUOutM = alu; WriteRegM = wr; v0M = v0; a0M = a0;
  endtask

  task automatic nop();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 32'd0, 32'd0);
  endtask

  task automatic bubble();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 32'd0, 32'd0);
  endtask

  initial begin
    //              fl    rw    m2r   sys   rd             alu            wr     v0      chk  e_rw  e_wr   e_res          e_stall
    vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         32'h0000_002A, 5'd8,  32'd0,  1'b1, 1'b1, 5'd8,  32'h0000_002A, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0,         5'd9,  32'd0,  1'b1, 1'b1, 5'd9,  32'hDEAD_BEEF, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h1234_5678, 32'h0,         5'd10, 32'd0,  1'b0, 1'b0, 5'd0,  32'h0,         1'b0};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0000_0055, 5'd3,  32'd0,  1'b1, 1'b0, 5'd3,  32'h0000_0055, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0,         32'h0000_0003, 5'd2,  32'd5,  1'b1, 1'b0, 5'd2,  32'h0000_0003, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         32'hFFFF_FFFF, 5'd31, 32'd0,  1'b1, 1'b1, 5'd31, 32'hFFFF_FFFF, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         32'h0000_0007, 5'd1,  32'd11, 1'b1, 1'b1, 5'd1,  32'h0000_0007, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h8000_0001, 32'h0000_0011, 5'd4,  32'd0,  1'b1, 1'b1, 5'd4,  32'h8000_0001, 1'b0};

    rst_n = 1'b0; stall_w = 1'b0; con_ready = 1'b0;
    bubble();
    #12;
    chk("rst_regwrite", {63'd0, RegWriteW}, 64'd0);
    chk("rst_writereg", {59'd0, WriteRegW}, 64'd0);
    chk("rst_result",   {32'd0, ResultW},   64'd0);
    chk("rst_stall",    {63'd0, stall_req}, 64'd0);
    chk("rst_convalid", {63'd0, con_valid}, 64'd0);
    chk("rst_condata",  {56'd0, con_data},  64'd0);
    chk("rst_halt",     {63'd0, halt},      64'd0);
    rst_n = 1'b1;
    tick();

    // Five retired ops followed by a flushed bubble.
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'(i + 1), 5'(i + 1), 32'd0, 32'd0);
      tick();
    end
    bubble();
    tick();
    tick();
`ifdef WB_INSTRET_COUNTER_EN
    chk("instret_5", instret, 64'd5);
`endif

    // Table-driven single-cycle vectors.
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].flush, vecs[i].rw, vecs[i].m2r, vecs[i].sys, vecs[i].rd,
            vecs[i].alu, vecs[i].wr, vecs[i].v0, 32'd0);
      tick();
      chk($sformatf("vec%0d_regwrite", i), {63'd0, RegWriteW}, {63'd0, vecs[i].exp_rw});
      chk($sformatf("vec%0d_stall", i),    {63'd0, stall_req}, {63'd0, vecs[i].exp_stall});
      chk($sformatf("vec%0d_convalid", i), {63'd0, con_valid}, 64'd0);
      if (vecs[i].chk_data) begin
        chk($sformatf("vec%0d_writereg", i), {59'd0, WriteRegW}, {59'd0, vecs[i].exp_wr});
        chk($sformatf("vec%0d_result", i),   {32'd0, ResultW},   {32'd0, vecs[i].exp_res});
      end
    end

    // Print-char 'A' with con_ready low for three cycles, ALU op behind it.
    con_ready = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 5'd0, 32'd11, 32'h0000_0041);
    tick();
    chk("pc_pre_stall", {63'd0, stall_req}, 64'd0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'h0000_0099, 5'd5, 32'd0, 32'd0);
    tick();
    nop();
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("pc_valid_c%0d", c), {63'd0, con_valid}, 64'd1);
      chk($sformatf("pc_data_c%0d", c),  {56'd0, con_data},  64'h41);
      chk($sformatf("pc_stall_c%0d", c), {63'd0, stall_req}, 64'd1);
      chk($sformatf("pc_nowrite_c%0d", c), {63'd0, RegWriteW}, 64'd0);
      if (c == 3) con_ready = 1'b1;
      tick();
    end
    con_ready = 1'b0;
    chk("pc_done_valid", {63'd0, con_valid}, 64'd0);
    chk("pc_done_stall", {63'd0, stall_req}, 64'd0);
    chk("pc_alu_write",  {63'd0, RegWriteW}, 64'd1);
    chk("pc_alu_wr",     {59'd0, WriteRegW}, 64'd5);
    chk("pc_alu_res",    {32'd0, ResultW},   64'h99);
    tick();
    chk("pc_alu_once",   {63'd0, RegWriteW}, 64'd0);

    // Back-to-back print-chars 'H' then 'i' with con_ready tied high.
    hs_q.delete();
    con_ready = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 5'd0, 32'd11, 32'h0000_0048);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 5'd0, 32'd11, 32'h0000_0069);
    tick();
    nop();
    for (int c = 0; c < 6; c++) tick();
    chk("hi_count", 64'(hs_q.size()), 64'd2);
    chk("hi_first",  {56'd0, (hs_q.size() > 0) ? hs_q[0] : 8'h00}, 64'h48);
    chk("hi_second", {56'd0, (hs_q.size() > 1) ? hs_q[1] : 8'h00}, 64'h69);
    con_ready = 1'b0;

    // Exit, then a register-writing instruction that must be suppressed.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 5'd0, 32'd10, 32'd0);
    tick();
    chk("ex_pre_halt", {63'd0, halt}, 64'd0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'h0000_0001, 5'd4, 32'd0, 32'd0);
    tick();
    nop();
    for (int c = 0; c < 20; c++) begin
      chk($sformatf("ex_halt_c%0d", c),    {63'd0, halt},      64'd1);
      chk($sformatf("ex_stall_c%0d", c),   {63'd0, stall_req}, 64'd1);
      chk($sformatf("ex_nowrite_c%0d", c), {63'd0, RegWriteW}, 64'd0);
      chk($sformatf("ex_novalid_c%0d", c), {63'd0, con_valid}, 64'd0);
      tick();
    end
    #2 rst_n = 1'b0;
    #1;
    chk("ex_rst_halt",  {63'd0, halt},      64'd0);
    chk("ex_rst_stall", {63'd0, stall_req}, 64'd0);
    bubble();
    #1 rst_n = 1'b1;
    tick();

    // Asynchronous reset in the middle of an emission.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 5'd0, 32'd11, 32'h0000_005A);
    tick();
    nop();
    tick();
    chk("er_in_emit", {63'd0, con_valid}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("er_valid", {63'd0, con_valid}, 64'd0);
    chk("er_stall", {63'd0, stall_req}, 64'd0);
    chk("er_halt",  {63'd0, halt},      64'd0);
    chk("er_data",  {56'd0, con_data},  64'd0);
    bubble();
    #1 rst_n = 1'b1;
    tick();
    tick();
    chk("er_after_valid", {63'd0, con_valid}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Final pipeline stage of the MIPS CPU. Directly consumes the memory-stage outputs and holds the MEM/WB pipeline register.
- Selects the register-file write-back value (ResultW) and drives the write port and hazard-unit forwarding signals.
- Executes syscalls at retirement: print-char goes out on a valid/ready console handshake; exit halts the core.

Parameters:
- DATA_W, 32, datapath width
- REG_AW, 5, register index width
- CON_W, 8, console character width

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- stall_w  in  1  hazard unit: hold MEM/WB register
- flush_w  in  1  hazard unit: insert bubble into MEM/WB
- RegWriteM  in  1  register-write enable from memory stage
- MemToRegM  in  1  select memory read data as result
- syscallM  in  1  instruction is a syscall
- ReadDataM  in  DATA_W  data memory read data
- ALUOutM  in  DATA_W  ALU result
- WriteRegM  in  REG_AW  destination register
- v0M  in  DATA_W  $v0 value (syscall code)
- a0M  in  DATA_W  $a0 value (syscall argument)
- RegWriteW  out  1  register-file write enable
- WriteRegW  out  REG_AW  register-file write address
- ResultW  out  DATA_W  register-file write data; also forwarded
- stall_req  out  1  request that hazard unit stall all earlier stages
- con_valid  out  1  console character valid
- con_data  out  CON_W  console character
- con_ready  in  1  console accepts character
- halt  out  1  sticky; core has executed exit

Behaviour:
- Reset is asynchronous and active-low:
  - clears every MEM/WB register field to 0 and returns the FSM to IDLE.
  - Outputs: RegWriteW=0, WriteRegW=0, ResultW=0, stall_req=0, con_valid=0, con_data=0, halt=0.
  - Reset mid-EMIT drops con_valid immediately; the character is lost.
- MEM/WB register update on posedge clk, in priority order:
  - flush_w: clears RegWrite, syscall and valid bits; data fields are don't-care.
  - else if stall_w or stall_req: hold all fields.
  - else: capture all M inputs and set valid=1.
- ResultW = MemToReg ? ReadData : ALUOut, taken combinationally from registered fields. Latency: 1 cycle from M inputs to W outputs.
- WriteRegW comes from the register.
- RegWriteW = reg_RegWrite & valid & (state==IDLE) & !halt. A held instruction therefore writes exactly once, after the FSM returns to IDLE.
- Syscall FSM, states IDLE, EMIT, HALTED:
  - IDLE, with a valid registered syscall:
    - v0==11: go to EMIT and latch con_data=a0[7:0].
    - v0==10: go to HALTED.
    - any other v0: ignored, stay in IDLE.
  - The syscall is consumed at that edge. The register may load the next instruction on the same edge.
  - EMIT:
    - con_valid=1 and stall_req=1.
    - con_data holds stable until accepted.
    - On con_valid & con_ready: return to IDLE. con_valid and stall_req deassert the following cycle.
    - Minimum occupancy is one cycle.
  - HALTED: halt=1 and stall_req=1. Terminal until reset. con_valid=0 and all register writes are suppressed.
- stall_req = (state != IDLE), registered state only; there is no combinational path from con_ready.
- flush_w during EMIT clears the register but does not abort the emission.
- A syscall arriving while in EMIT is held in the register and taken on return to IDLE. Back-to-back print-chars therefore emit in order with no loss.
- Non-syscall instructions never touch the FSM.

Optional Feature:
- Macro: WB_INSTRET_COUNTER_EN.
- When defined:
  - adds output instret (64 bits). It increments by 1 on each edge where a valid instruction leaves WB: valid, state IDLE, and the register not held.
  - Syscalls are counted. Bubbles are not counted.
  - Saturates at all-ones, resets to 0, and freezes when halt=1.
- When undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package mips_pkg holds:
  - syscall code constants: SYS_PRINT_CHAR=11, SYS_EXIT=10
  - the FSM state enum (IDLE/EMIT/HALTED)
  - width constants shared with the memory stage
- One natural sub-module: mem_wb_reg, the flushable/stallable pipeline register. The FSM and result mux stay in the top module.

Test Plan:
- ALU op: RegWriteM=1, MemToRegM=0, ALUOutM=0x0000_002A, WriteRegM=8 -> next cycle RegWriteW=1, WriteRegW=8, ResultW=0x2A.
- Load: MemToRegM=1, ReadDataM=0xDEAD_BEEF -> ResultW=0xDEADBEEF.
- Flush: flush_w asserted on the same cycle as the load -> RegWriteW=0.
- Print-char with back-pressure: syscall, v0=11, a0=0x41, con_ready low 3 cycles ->
  - con_valid=1 and con_data=0x41 stable for 4 cycles; stall_req=1 throughout.
  - The following ALU op writes once, only after the handshake completes.
- Two consecutive print-chars 'H' (0x48) and 'i' (0x69), con_ready tied 1 -> exactly two handshakes, in order 0x48 then 0x69.
- Exit: syscall v0=10 -> halt=1 and stall_req=1 from the next cycle. A subsequent RegWriteM=1 instruction gives RegWriteW=0. Stays halted for 20 cycles until rst_n=0.
- Async reset asserted mid-EMIT (between clock edges) -> con_valid, stall_req and halt go to 0 immediately. With WB_INSTRET_COUNTER_EN: after 5 retired ops and 1 bubble, instret=5.
